// File: rtl/ssd_ctrl_pkg.sv
// Shared definitions for the 2-bit burst stream controllers: FSM encoding, symbol geometry
// and the byte-length to symbol-count conversion.
package ssd_ctrl_pkg;

  localparam int unsigned SYM_W         = 2;
  localparam int unsigned SYMS_PER_BYTE = 4;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StHunt    = 2'd1,
    StRecvPos = 2'd2,
    StRecvNeg = 2'd3
  } state_e;

  // Four 2-bit symbols per byte; the top two length bits cannot be represented.
  function automatic logic [31:0] len_to_syms(input logic [31:0] x);
    return {x[29:0], 2'b00};
  endfunction

endpackage

// File: rtl/sym_packer_2bit.sv
// Shifts 2-bit symbols MSB-first into bytes; byte_rdy pulses combinationally with the
// fourth pushed symbol, and byte_data carries the completed byte in that cycle.
module sym_packer_2bit
  import ssd_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             nRST,
  input  logic             clr,
  input  logic             push,
  input  logic [SYM_W-1:0] sym,
  output logic             byte_rdy,
  output logic [7:0]       byte_data
);

  localparam int unsigned ShiftW = SYM_W * (SYMS_PER_BYTE - 1);

  logic [ShiftW-1:0] shift_q;
  logic [1:0]        cnt_q;

  assign byte_rdy  = push && !clr && (cnt_q == 2'(SYMS_PER_BYTE - 1));
  assign byte_data = {shift_q, sym};

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clr) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (push) begin
      shift_q <= {shift_q[ShiftW-SYM_W-1:0], sym};
      cnt_q   <= cnt_q + 2'd1;
    end
  end

endmodule

// File: rtl/sinkin_ctrl_2bit.sv
// Receive-side controller for the 2-bit burst stream: burst/gap synchronisation, byte
// packing with an overflow gate, length/gap checking, lock tracking and status counters.
module sinkin_ctrl_2bit
  import ssd_ctrl_pkg::*;
#(
  parameter logic [14:0] FIFO_HIGH   = 15'd30000,
  parameter int unsigned LOCK_FRAMES = 4
) (
  input  logic        clk,
  input  logic        nRST,
  input  logic [31:0] data_length,
  input  logic [31:0] blank_length,
  input  logic        data_en,
  input  logic [1:0]  data_in,
  input  logic [14:0] fifo_wrusedw,
  input  logic        fifo_full,
  output logic        fifo_wrreq,
  output logic [7:0]  fifo_data,
  output logic        locked,
  output logic [31:0] frame_cnt,
  output logic [15:0] len_err_cnt,
  output logic [15:0] gap_err_cnt,
  output logic [15:0] ovf_cnt
);

  logic        en_r;
  logic [1:0]  sym_r;
  state_e      state_q, state_d;
  logic [31:0] pos_num_q, pos_num_d;
  logic [31:0] neg_num_q, neg_num_d;
  logic [31:0] sym_cnt_q, sym_cnt_d;
  logic [31:0] gap_cnt_q, gap_cnt_d;
  logic        seen_low_q, seen_low_d;
  logic        gap_bad_q, gap_bad_d;
  logic        push, clr, good_frame, len_err, gap_err;
  logic        byte_rdy, blocked;
  logic [7:0]  byte_data;
  logic [31:0] lock_cnt_q;
  logic        wrreq_q;
  logic [7:0]  data_q;
  logic [31:0] frame_cnt_q;
  logic [15:0] len_err_q, gap_err_q, ovf_q;

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      en_r  <= 1'b0;
      sym_r <= '0;
    end else begin
      en_r  <= data_en;
      sym_r <= data_in;
    end
  end

  always_comb begin
    state_d    = state_q;
    pos_num_d  = pos_num_q;
    neg_num_d  = neg_num_q;
    sym_cnt_d  = sym_cnt_q;
    gap_cnt_d  = gap_cnt_q;
    seen_low_d = seen_low_q;
    gap_bad_d  = gap_bad_q;
    push       = 1'b0;
    clr        = 1'b0;
    good_frame = 1'b0;
    len_err    = 1'b0;
    gap_err    = 1'b0;
    unique case (state_q)
      StIdle: begin
        pos_num_d  = len_to_syms(data_length);
        neg_num_d  = len_to_syms(blank_length);
        clr        = 1'b1;
        seen_low_d = 1'b0;
        if (pos_num_d != 32'd0) state_d = StHunt;
      end
      StHunt: begin
        if (!en_r) begin
          seen_low_d = 1'b1;
          clr        = 1'b1;
        end else if (seen_low_q) begin
          push      = 1'b1;
          sym_cnt_d = 32'd1;
          gap_bad_d = 1'b0;
          state_d   = StRecvPos;
        end else begin
          clr = 1'b1;
        end
      end
      StRecvPos: begin
        if (en_r) begin
          if (sym_cnt_q == pos_num_q) begin
            len_err    = 1'b1;
            clr        = 1'b1;
            seen_low_d = 1'b0;
            state_d    = StHunt;
          end else begin
            push = 1'b1;
            // Continuous stream: frame boundary is the last symbol, not a falling edge.
            if (neg_num_q == 32'd0 && sym_cnt_q == pos_num_q - 32'd1) begin
              good_frame = 1'b1;
              sym_cnt_d  = 32'd0;
            end else begin
              sym_cnt_d = sym_cnt_q + 32'd1;
            end
          end
        end else begin
          if (sym_cnt_q == pos_num_q) good_frame = 1'b1;
          else if (sym_cnt_q != 32'd0) len_err = 1'b1;
          clr       = 1'b1;
          gap_cnt_d = 32'd1;
          state_d   = StRecvNeg;
        end
      end
      StRecvNeg: begin
        if (!en_r) begin
          if (gap_cnt_q != '1) gap_cnt_d = gap_cnt_q + 32'd1;
        end else begin
          gap_err   = (gap_cnt_q != neg_num_q);
          gap_bad_d = gap_err;
          push      = 1'b1;
          sym_cnt_d = 32'd1;
          state_d   = StRecvPos;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      state_q    <= StIdle;
      pos_num_q  <= '0;
      neg_num_q  <= '0;
      sym_cnt_q  <= '0;
      gap_cnt_q  <= '0;
      seen_low_q <= 1'b0;
      gap_bad_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_num_q  <= pos_num_d;
      neg_num_q  <= neg_num_d;
      sym_cnt_q  <= sym_cnt_d;
      gap_cnt_q  <= gap_cnt_d;
      seen_low_q <= seen_low_d;
      gap_bad_q  <= gap_bad_d;
    end
  end

  sym_packer_2bit u_packer (
    .clk      (clk),
    .nRST     (nRST),
    .clr      (clr),
    .push     (push),
    .sym      (sym_r),
    .byte_rdy (byte_rdy),
    .byte_data(byte_data)
  );

  assign blocked = fifo_full || (fifo_wrusedw >= FIFO_HIGH);

  always_ff @(posedge clk or negedge nRST) begin
    if (!nRST) begin
      wrreq_q     <= 1'b0;
      data_q      <= '0;
      ovf_q       <= '0;
      frame_cnt_q <= '0;
      len_err_q   <= '0;
      gap_err_q   <= '0;
      lock_cnt_q  <= '0;
    end else begin
      wrreq_q <= byte_rdy && !blocked;
      if (byte_rdy && !blocked) data_q <= byte_data;
      if (byte_rdy && blocked && ovf_q != '1) ovf_q <= ovf_q + 16'd1;
      if (good_frame && frame_cnt_q != '1) frame_cnt_q <= frame_cnt_q + 32'd1;
      if (len_err && len_err_q != '1) len_err_q <= len_err_q + 16'd1;
      if (gap_err && gap_err_q != '1) gap_err_q <= gap_err_q + 16'd1;
      // A frame following a bad gap is good for frame_cnt but does not build lock.
      if (len_err || gap_err) lock_cnt_q <= '0;
      else if (good_frame && !gap_bad_q && lock_cnt_q < LOCK_FRAMES)
        lock_cnt_q <= lock_cnt_q + 32'd1;
    end
  end

  assign fifo_wrreq  = wrreq_q;
  assign fifo_data   = data_q;
  assign locked      = (lock_cnt_q >= LOCK_FRAMES);
  assign frame_cnt   = frame_cnt_q;
  assign len_err_cnt = len_err_q;
  assign gap_err_cnt = gap_err_q;
  assign ovf_cnt     = ovf_q;

endmodule

// File: tb/tb_sinkin_ctrl_2bit.sv
// Directed bench for sinkin_ctrl_2bit: nominal capture, length/gap errors, continuous
// stream, FIFO overflow and reset in the middle of a burst.
module tb_sinkin_ctrl_2bit;

  logic        clk = 1'b0;
  logic        nRST;
  logic [31:0] data_length, blank_length;
  logic        data_en;
  logic [1:0]  data_in;
  logic [14:0] fifo_wrusedw;
  logic        fifo_full;
  logic        fifo_wrreq;
  logic [7:0]  fifo_data;
  logic        locked;
  logic [31:0] frame_cnt;
  logic [15:0] len_err_cnt, gap_err_cnt, ovf_cnt;

  int n_vec = 0;
  int n_err = 0;
  int cyc = 0;
  int         wr_cyc[$];
  logic [7:0] wr_dat[$];
  int         exp_cyc[$];
  logic [7:0] exp_dat[$];

  sinkin_ctrl_2bit dut (
    .clk         (clk),
    .nRST        (nRST),
    .data_length (data_length),
    .blank_length(blank_length),
    .data_en     (data_en),
    .data_in     (data_in),
    .fifo_wrusedw(fifo_wrusedw),
    .fifo_full   (fifo_full),
    .fifo_wrreq  (fifo_wrreq),
    .fifo_data   (fifo_data),
    .locked      (locked),
    .frame_cnt   (frame_cnt),
    .len_err_cnt (len_err_cnt),
    .gap_err_cnt (gap_err_cnt),
    .ovf_cnt     (ovf_cnt)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (fifo_wrreq === 1'b1) begin
      wr_cyc.push_back(cyc);
      wr_dat.push_back(fifo_data);
    end
  end

  // Per-burst symbol pattern 0,1,2,3,3,2,1,0 -> bytes 0x1B, 0xE4.
  function automatic logic [1:0] sym_at(input int i);
    case (i % 8)
      0, 7:    return 2'd0;
      1, 6:    return 2'd1;
      2, 5:    return 2'd2;
      default: return 2'd3;
    endcase
  endfunction

  task automatic step(input logic en, input logic [1:0] s);
    data_en = en;
    data_in = s;
    @(posedge clk);
    #1;
  endtask

  task automatic gap(input int n);
    repeat (n) step(1'b0, 2'd0);
  endtask

  task automatic burst(input int n, input bit exp_wr);
    logic [7:0] acc;
    acc = 8'h00;
    for (int i = 0; i < n; i++) begin
      acc = {acc[5:0], sym_at(i)};
      if (exp_wr && (i % 4 == 3)) begin
        exp_cyc.push_back(cyc + 2);
        exp_dat.push_back(acc);
      end
      step(1'b1, sym_at(i));
    end
  endtask

  task automatic clear_q();
    wr_cyc.delete();
    wr_dat.delete();
    exp_cyc.delete();
    exp_dat.delete();
  endtask

  task automatic apply_reset(input int dl, input int bl);
    nRST         = 1'b0;
    data_en      = 1'b0;
    data_in      = 2'd0;
    data_length  = 32'(dl);
    blank_length = 32'(bl);
    fifo_wrusedw = 15'd0;
    fifo_full    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nRST = 1'b1;
    clear_q();
  endtask

  task automatic test_reset();
    n_vec++;
    if ({fifo_wrreq, fifo_data, locked} !== 10'd0) begin
      n_err++;
      $display("FAIL reset_out: got wrreq=%b data=%h locked=%b want 0 0 0",
               fifo_wrreq, fifo_data, locked);
    end
    n_vec++;
    if (frame_cnt !== 32'd0) begin
      n_err++; $display("FAIL reset_frame_cnt: got %0d want 0", frame_cnt);
    end
    n_vec++;
    if ({len_err_cnt, gap_err_cnt, ovf_cnt} !== 48'd0) begin
      n_err++;
      $display("FAIL reset_err_cnts: got len=%0d gap=%0d ovf=%0d want 0 0 0",
               len_err_cnt, gap_err_cnt, ovf_cnt);
    end
  endtask

  task automatic test_nominal();
    apply_reset(2, 1);
    gap(4);
    for (int f = 1; f <= 6; f++) begin
      burst(8, 1'b1);
      gap(4);
      if (f == 3 || f == 4) begin
        n_vec++;
        if (locked !== (f == 4)) begin
          n_err++; $display("FAIL nom_locked_f%0d: got %b want %b", f, locked, f == 4);
        end
      end
    end
    n_vec++;
    if (frame_cnt !== 32'd6) begin
      n_err++; $display("FAIL nom_frame_cnt: got %0d want 6", frame_cnt);
    end
    n_vec++;
    if ({len_err_cnt, gap_err_cnt, ovf_cnt} !== 48'd0) begin
      n_err++;
      $display("FAIL nom_errs: got len=%0d gap=%0d ovf=%0d want 0 0 0",
               len_err_cnt, gap_err_cnt, ovf_cnt);
    end
    n_vec++;
    if (wr_cyc.size() != 12) begin
      n_err++; $display("FAIL nom_wr_count: got %0d want 12", wr_cyc.size());
    end
    for (int k = 0; k < wr_cyc.size() && k < exp_cyc.size(); k++) begin
      n_vec++;
      if (wr_cyc[k] != exp_cyc[k] || wr_dat[k] !== ((k % 2 == 0) ? 8'h1B : 8'hE4)) begin
        n_err++;
        $display("FAIL nom_wr[%0d]: got cyc %0d data %h want cyc %0d data %h", k, wr_cyc[k],
                 wr_dat[k], exp_cyc[k], (k % 2 == 0) ? 8'h1B : 8'hE4);
      end
    end
  endtask

  task automatic test_short_burst();
    clear_q();
    burst(7, 1'b1);
    gap(4);
    n_vec++;
    if (len_err_cnt !== 16'd1) begin
      n_err++; $display("FAIL short_len_err: got %0d want 1", len_err_cnt);
    end
    n_vec++;
    if (locked !== 1'b0) begin
      n_err++; $display("FAIL short_locked_drop: got %b want 0", locked);
    end
    n_vec++;
    if (wr_cyc.size() != 1 || wr_dat.size() != 1 || wr_dat[0] !== 8'h1B) begin
      n_err++;
      $display("FAIL short_writes: got %0d writes first %h want 1 write 1b", wr_cyc.size(),
               (wr_dat.size() > 0) ? wr_dat[0] : 8'hxx);
    end
    for (int f = 1; f <= 4; f++) begin
      burst(8, 1'b0);
      gap(4);
      if (f >= 3) begin
        n_vec++;
        if (locked !== (f == 4)) begin
          n_err++; $display("FAIL short_relock_f%0d: got %b want %b", f, locked, f == 4);
        end
      end
    end
    n_vec++;
    if (frame_cnt !== 32'd10) begin
      n_err++; $display("FAIL short_frame_cnt: got %0d want 10", frame_cnt);
    end
  endtask

  task automatic test_gap_error();
    clear_q();
    gap(1);  // previous gap(4) plus this one gives 5 low cycles
    burst(8, 1'b1);
    gap(4);
    n_vec++;
    if (gap_err_cnt !== 16'd1 || len_err_cnt !== 16'd1) begin
      n_err++;
      $display("FAIL gap_err_cnts: got gap=%0d len=%0d want 1 1", gap_err_cnt, len_err_cnt);
    end
    n_vec++;
    if (frame_cnt !== 32'd11 || locked !== 1'b0) begin
      n_err++;
      $display("FAIL gap_frame_lock: got frame=%0d locked=%b want 11 0", frame_cnt, locked);
    end
    n_vec++;
    if (wr_cyc.size() != 2) begin
      n_err++; $display("FAIL gap_wr_count: got %0d want 2", wr_cyc.size());
    end
    for (int k = 0; k < wr_cyc.size() && k < exp_cyc.size(); k++) begin
      n_vec++;
      if (wr_cyc[k] != exp_cyc[k] || wr_dat[k] !== exp_dat[k]) begin
        n_err++;
        $display("FAIL gap_wr[%0d]: got cyc %0d data %h want cyc %0d data %h", k, wr_cyc[k],
                 wr_dat[k], exp_cyc[k], exp_dat[k]);
      end
    end
  endtask

  task automatic test_overflow();
    apply_reset(2, 1);
    gap(4);
    repeat (4) begin
      burst(8, 1'b0);
      gap(4);
    end
    clear_q();
    fifo_wrusedw = 15'd30000;
    burst(8, 1'b0);
    gap(4);
    fifo_wrusedw = 15'd0;
    n_vec++;
    if (wr_cyc.size() != 0 || ovf_cnt !== 16'd2) begin
      n_err++;
      $display("FAIL ovf_high: got %0d writes ovf=%0d want 0 writes ovf=2", wr_cyc.size(),
               ovf_cnt);
    end
    n_vec++;
    if (locked !== 1'b1) begin
      n_err++; $display("FAIL ovf_locked: got %b want 1", locked);
    end
    fifo_wrusedw = 15'd29999;  // one below the watermark still writes
    burst(8, 1'b1);
    gap(4);
    fifo_wrusedw = 15'd0;
    fifo_full = 1'b1;
    burst(8, 1'b0);
    gap(4);
    fifo_full = 1'b0;
    n_vec++;
    if (ovf_cnt !== 16'd4) begin
      n_err++; $display("FAIL ovf_full_cnt: got %0d want 4", ovf_cnt);
    end
    n_vec++;
    if (wr_cyc.size() != 2) begin
      n_err++; $display("FAIL ovf_wr_count: got %0d want 2", wr_cyc.size());
    end
    for (int k = 0; k < wr_cyc.size() && k < exp_cyc.size(); k++) begin
      n_vec++;
      if (wr_cyc[k] != exp_cyc[k] || wr_dat[k] !== exp_dat[k]) begin
        n_err++;
        $display("FAIL ovf_wr[%0d]: got cyc %0d data %h want cyc %0d data %h", k, wr_cyc[k],
                 wr_dat[k], exp_cyc[k], exp_dat[k]);
      end
    end
    n_vec++;
    if (frame_cnt !== 32'd7 || locked !== 1'b1 || len_err_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL ovf_status: got frame=%0d locked=%b len=%0d want 7 1 0", frame_cnt, locked,
               len_err_cnt);
    end
  endtask

  task automatic test_continuous();
    apply_reset(2, 0);
    gap(4);
    burst(24, 1'b1);
    gap(4);
    n_vec++;
    if (frame_cnt !== 32'd3) begin
      n_err++; $display("FAIL cont_frame_cnt: got %0d want 3", frame_cnt);
    end
    n_vec++;
    if (len_err_cnt !== 16'd0 || gap_err_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL cont_errs: got len=%0d gap=%0d want 0 0", len_err_cnt, gap_err_cnt);
    end
    n_vec++;
    if (wr_cyc.size() != 6) begin
      n_err++; $display("FAIL cont_wr_count: got %0d want 6", wr_cyc.size());
    end
    for (int k = 0; k < wr_cyc.size() && k < exp_cyc.size(); k++) begin
      n_vec++;
      if (wr_cyc[k] != exp_cyc[k] || wr_dat[k] !== ((k % 2 == 0) ? 8'h1B : 8'hE4)) begin
        n_err++;
        $display("FAIL cont_wr[%0d]: got cyc %0d data %h want cyc %0d", k, wr_cyc[k],
                 wr_dat[k], exp_cyc[k]);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    apply_reset(2, 1);
    gap(4);
    repeat (2) begin
      burst(8, 1'b1);
      gap(4);
    end
    n_vec++;
    if (wr_cyc.size() != 4 || frame_cnt !== 32'd2) begin
      n_err++;
      $display("FAIL mid_pre: got %0d writes frame=%0d want 4 2", wr_cyc.size(), frame_cnt);
    end
    step(1'b1, sym_at(0));
    step(1'b1, sym_at(1));
    nRST = 1'b0;
    #1;
    n_vec++;
    if ({fifo_wrreq, fifo_data, locked} !== 10'd0 || frame_cnt !== 32'd0) begin
      n_err++;
      $display("FAIL mid_async_clear: got wrreq=%b data=%h locked=%b frame=%0d want all 0",
               fifo_wrreq, fifo_data, locked, frame_cnt);
    end
    clear_q();
    @(posedge clk);
    #1;
    nRST = 1'b1;
    for (int i = 2; i < 8; i++) step(1'b1, sym_at(i));  // tail of the interrupted burst
    n_vec++;
    if (wr_cyc.size() != 0) begin
      n_err++; $display("FAIL mid_no_partial: got %0d writes want 0", wr_cyc.size());
    end
    gap(4);
    burst(8, 1'b1);
    gap(4);
    n_vec++;
    if (frame_cnt !== 32'd1 || len_err_cnt !== 16'd0 || gap_err_cnt !== 16'd0) begin
      n_err++;
      $display("FAIL mid_recapture: got frame=%0d len=%0d gap=%0d want 1 0 0", frame_cnt,
               len_err_cnt, gap_err_cnt);
    end
    n_vec++;
    if (wr_cyc.size() != 2) begin
      n_err++; $display("FAIL mid_wr_count: got %0d want 2", wr_cyc.size());
    end
    for (int k = 0; k < wr_cyc.size() && k < exp_cyc.size(); k++) begin
      n_vec++;
      if (wr_cyc[k] != exp_cyc[k] || wr_dat[k] !== exp_dat[k]) begin
        n_err++;
        $display("FAIL mid_wr[%0d]: got cyc %0d data %h want cyc %0d data %h", k, wr_cyc[k],
                 wr_dat[k], exp_cyc[k], exp_dat[k]);
      end
    end
  endtask

  initial begin
    nRST         = 1'b0;
    data_en      = 1'b0;
    data_in      = 2'd0;
    data_length  = 32'd2;
    blank_length = 32'd1;
    fifo_wrusedw = 15'd0;
    fifo_full    = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_nominal();
    test_short_burst();
    test_gap_error();
    test_overflow();
    test_continuous();
    test_reset_mid_burst();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
